// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer chain: collector FSM states, default pixel
// width, and the conv/pool output-size helpers that the feature-map sizes derive from.
package cnn_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DW_DEFAULT = 16;

  // Layer-1 geometry: 8x8 image, 2x2 kernel at stride 2, then 2:1 pooling.
  localparam int IMG_N    = 8;
  localparam int IMG_M    = 8;
  localparam int K_SIZE   = 2;
  localparam int K_STRIDE = 2;
  localparam int P_STRIDE = 2;

  function automatic int conv_out(input int in_size, input int k, input int stride);
    return (in_size - k) / stride + 1;
  endfunction

  function automatic int pool_out(input int in_size, input int stride);
    return in_size / stride;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int OW_DEFAULT = pool_out(conv_out(IMG_N, K_SIZE, K_STRIDE), P_STRIDE);
  localparam int OH_DEFAULT = pool_out(conv_out(IMG_M, K_SIZE, K_STRIDE), P_STRIDE);

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port frame RAM: synchronous write, synchronous read with read enable.
// rd_data holds its value while rd_en is low, so it doubles as the prefetch stage.
module fmap_ram #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fmap_collector.sv
// Frame buffer between layers: captures one OW x OH feature map, then replays it in
// raster order over valid/ready. Build with FMAP_RELU_EN to clamp negative pixels to 0.
module fmap_collector
  import cnn_pkg::*;
#(
  parameter int OW = OW_DEFAULT,
  parameter int OH = OH_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DW-1:0]                i_pixel,
  input  logic                         i_data_valid,
  output logic [DW-1:0]                o_pixel,
  output logic                         o_data_valid,
  input  logic                         i_ready,
  output logic [$clog2(OW*OH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_frame_done,
  output logic                         o_overflow
);

  localparam int DEPTH = OW * OH;
  localparam int AW    = addr_width(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic [CW-1:0] out_cnt_reg;
  logic          pf_valid_reg;
  logic [DW-1:0] pixel_reg;
  logic          valid_reg;
  logic          overflow_reg;

  logic          wr_en;
  logic          last_write;
  logic          xfer;
  logic          last_beat;
  logic          out_load;
  logic          rd_issue;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

`ifdef FMAP_RELU_EN
  assign wr_data = i_pixel[DW-1] ? '0 : i_pixel;
`else
  assign wr_data = i_pixel;
`endif

  always_comb begin
    state_next = state_reg;
    wr_en      = (state_reg == FILL) && i_data_valid;
    last_write = wr_en && (count_reg == LAST);
    xfer       = valid_reg && i_ready;
    last_beat  = xfer && (out_cnt_reg == LAST);
    out_load   = pf_valid_reg && (!valid_reg || i_ready);
    // The read of mem[0] is issued alongside the final write so the first beat
    // lands two cycles after it.
    rd_issue   = (last_write || ((state_reg == DRAIN) && (rd_ptr_reg < DEPTH_C)))
                 && (!pf_valid_reg || out_load);
    case (state_reg)
      FILL:    if (last_write) state_next = DRAIN;
      DRAIN:   if (last_beat)  state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FILL;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      out_cnt_reg  <= '0;
      pf_valid_reg <= 1'b0;
      pixel_reg    <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (wr_en) begin
        count_reg <= last_write ? '0 : count_reg + CW'(1);
      end

      if ((state_reg == DRAIN) && i_data_valid) begin
        overflow_reg <= 1'b1;
      end

      if (rd_issue) begin
        rd_ptr_reg   <= rd_ptr_reg + CW'(1);
        pf_valid_reg <= 1'b1;
      end else if (out_load) begin
        pf_valid_reg <= 1'b0;
      end

      if (out_load) begin
        pixel_reg <= rd_data;
        valid_reg <= 1'b1;
      end else if (xfer) begin
        valid_reg <= 1'b0;
      end

      if (xfer) begin
        out_cnt_reg <= last_beat ? '0 : out_cnt_reg + CW'(1);
      end

      if (last_beat) begin
        rd_ptr_reg <= '0;
      end
    end
  end

  fmap_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_reg[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_data)
  );

  assign o_pixel      = pixel_reg;
  assign o_data_valid = valid_reg;
  assign o_count      = count_reg;
  assign o_full       = (state_reg == DRAIN);
  assign o_frame_done = last_beat;
  assign o_overflow   = overflow_reg;

endmodule

// File: tb/tb_fmap_collector.sv
// Scoreboard bench for fmap_collector (2x2 frames): expected pixels are queued as
// they are driven and compared as beats transfer; honours FMAP_RELU_EN in its model.
module tb_fmap_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_pixel;
  logic        i_data_valid;
  logic [15:0] o_pixel;
  logic        o_data_valid;
  logic        i_ready;
  logic [2:0]  o_count;
  logic        o_full;
  logic        o_frame_done;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [15:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_pix  = '0;

  fmap_collector dut (
    .clk          (clk),
    .reset        (reset),
    .i_pixel      (i_pixel),
    .i_data_valid (i_data_valid),
    .o_pixel      (o_pixel),
    .o_data_valid (o_data_valid),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] p);
`ifdef FMAP_RELU_EN
    return p[15] ? 16'h0000 : p;
`else
    return p;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input logic [15:0] p3);
    logic [15:0] px [4];
    px = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) begin
      check("fill_count", 32'(o_count), 32'(i));
      i_data_valid = 1'b1;
      i_pixel      = px[i];
      sb.push_back(model(px[i]));
      tick();
    end
    i_data_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || o_full) && n < 40) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 40), 32'd1);
  endtask

  // Monitor: compares every transferred beat and the hold-while-stalled rule.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(o_data_valid), 32'd1);
        check("hold_pixel", 32'(o_pixel), 32'(stall_pix));
      end
      if (o_data_valid && i_ready) begin
        check("beat_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          logic [15:0] exp;
          exp = sb.pop_front();
          $display("beat %0d pixel=%h exp=%h done=%0d", beats, o_pixel, exp, o_frame_done);
          check("pixel", 32'(o_pixel), 32'(exp));
        end
        check("frame_done", 32'(o_frame_done), 32'(beats % 4 == 3));
        beats++;
      end else begin
        check("frame_done_idle", 32'(o_frame_done), 32'd0);
      end
      stall_prev = o_data_valid && !i_ready;
      stall_pix  = o_pixel;
    end
  end

  initial begin
    int b0;
    logic [6:0] pat;
    reset = 1'b1; i_pixel = '0; i_data_valid = 1'b0; i_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_pixel", 32'(o_pixel), 32'd0);
    check("rst_valid", 32'(o_data_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);

    // Basic replay and 2-cycle latency.
    send_frame(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    check("lat_full", 32'(o_full), 32'd1);
    check("lat_count", 32'(o_count), 32'd0);
    check("lat_valid_early", 32'(o_data_valid), 32'd0);
    tick();
    check("lat_valid", 32'(o_data_valid), 32'd1);
    check("lat_pixel", 32'(o_pixel), 32'h0010);
    wait_done();
    check("basic_full_clr", 32'(o_full), 32'd0);
    check("basic_valid_clr", 32'(o_data_valid), 32'd0);

    // Backpressure with ready pattern 1,0,0,1,1,0,1.
    i_ready = 1'b0;
    send_frame(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    for (int i = 0; i < 20 && !o_data_valid; i++) tick();
    check("bp_valid_seen", 32'(o_data_valid), 32'd1);
    b0  = beats;
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      i_ready = pat[i];
      tick();
    end
    check("bp_transfers", 32'(beats - b0), 32'd4);
    i_ready = 1'b1;
    wait_done();

    // Overflow: pixel during DRAIN is dropped and flagged.
    i_ready = 1'b0;
    send_frame(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    i_data_valid = 1'b1; i_pixel = 16'h00AA;
    tick();
    i_data_valid = 1'b0;
    check("ovf_set", 32'(o_overflow), 32'd1);
    tick(); tick();
    i_ready = 1'b1;
    wait_done();
    check("ovf_sticky", 32'(o_overflow), 32'd1);
    send_frame(16'h0505, 16'h0606, 16'h0707, 16'h0808);
    wait_done();
    check("ovf_sticky2", 32'(o_overflow), 32'd1);

    // Reset after 2 of 4 writes discards the partial frame.
    i_data_valid = 1'b1; i_pixel = 16'h0BAD; tick();
    i_pixel = 16'h0BAE; tick();
    i_data_valid = 1'b0;
    check("part_count", 32'(o_count), 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_count", 32'(o_count), 32'd0);
    check("mid_rst_full", 32'(o_full), 32'd0);
    check("mid_rst_overflow", 32'(o_overflow), 32'd0);
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    wait_done();

    // Back-to-back: frame B starts the cycle after A's frame_done.
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 20 && !o_frame_done; i++) @(negedge clk);
    check("b2b_done_seen", 32'(o_frame_done), 32'd1);
    tick();
    send_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    wait_done();
    check("b2b_no_overflow", 32'(o_overflow), 32'd0);

    // Signed inputs: clamped under FMAP_RELU_EN, unchanged otherwise.
    send_frame(16'hFFF0, 16'h0005, 16'h8000, 16'h7FFF);
    wait_done();
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
